// File: rtl/spmv_sched_pkg.sv
// Shared types and field positions for the SpMV kernel scheduler.
package spmv_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_RUN     = 2'd2,
    ST_DONE    = 2'd3
  } kern_state_t;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_ABORT_BIT   = 1;

  localparam int STAT_STATE_LSB   = 0;
  localparam int STAT_EMPTY_BIT   = 4;
  localparam int STAT_ABORTED_BIT = 5;
  localparam int STAT_LAUNCH_LSB  = 16;

  localparam int CFG_WORD_W       = 32;
  localparam int CFG_STRIDE       = 96;
  localparam int STAT_STRIDE      = 64;

  function automatic logic [31:0] pack_status(input kern_state_t st, input logic empty,
                                              input logic aborted, input logic [15:0] launch_cnt);
    logic [31:0] w;
    w = '0;
    w[STAT_STATE_LSB +: 2]   = st;
    w[STAT_EMPTY_BIT]        = empty;
    w[STAT_ABORTED_BIT]      = aborted;
    w[STAT_LAUNCH_LSB +: 16] = launch_cnt;
    return w;
  endfunction

endpackage

// File: rtl/spmv_rr_arbiter.sv
// Round-robin one-hot arbiter; search starts one past the last grant.
module spmv_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant   = '0;
    ptr_nxt = ptr_q;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_nxt    = PW'((int'(idx) + 1) % N);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) ptr_q <= '0;
    else          ptr_q <= ptr_nxt;
  end

endmodule

// File: rtl/spmv_kernel_scheduler.sv
// Launches up to MAX_ACTIVE SpMV kernels at once from per-kernel config words.
module spmv_kernel_scheduler
  import spmv_sched_pkg::*;
#(
  parameter int CONF_NUM_KERNEL = 4,
  parameter int MAX_ACTIVE      = 2
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [96*CONF_NUM_KERNEL-1:0] config_wire,
  output logic [CONF_NUM_KERNEL-1:0]    kern_start,
  output logic [32*CONF_NUM_KERNEL-1:0] kern_row_num,
  output logic [32*CONF_NUM_KERNEL-1:0] kern_nnz_num,
  output logic [CONF_NUM_KERNEL-1:0]    kern_abort,
  input  logic [CONF_NUM_KERNEL-1:0]    kern_done,
  output logic [64*CONF_NUM_KERNEL-1:0] status_wire,
  output logic                          all_idle
);

  localparam int N  = CONF_NUM_KERNEL;
  localparam int CW = $clog2(N + 1);

  kern_state_t   state_q    [N];
  logic [31:0]   run_cnt_q  [N];
  logic [15:0]   launch_q   [N];
  logic [31:0]   row_cfg    [N];
  logic [31:0]   nnz_cfg    [N];
  logic [N-1:0]  start_now, abort_now, start_q, abort_q;
  logic [N-1:0]  start_edge, abort_edge;
  logic [N-1:0]  empty_q, aborted_q;
  logic [N-1:0]  req, grant;
  logic [CW-1:0] active_cnt;
  logic          grant_en;
  logic          ctrl_hi_unused;

  always_comb begin
    ctrl_hi_unused = 1'b0;
    for (int i = 0; i < N; i++) begin
      start_now[i]   = config_wire[CFG_STRIDE*i + CTRL_START_BIT];
      abort_now[i]   = config_wire[CFG_STRIDE*i + CTRL_ABORT_BIT];
      row_cfg[i]     = config_wire[CFG_STRIDE*i + CFG_WORD_W   +: 32];
      nnz_cfg[i]     = config_wire[CFG_STRIDE*i + 2*CFG_WORD_W +: 32];
      ctrl_hi_unused = ctrl_hi_unused ^ (^config_wire[CFG_STRIDE*i + 2 +: 30]);
    end
    start_edge = start_now & ~start_q;
    abort_edge = abort_now & ~abort_q;
  end

  // A slot is counted busy while its kernel is still in RUN, so a done frees it one cycle later
  always_comb begin
    active_cnt = '0;
    all_idle   = 1'b1;
    for (int i = 0; i < N; i++) begin
      active_cnt = active_cnt + CW'(state_q[i] == ST_RUN);
      req[i]     = (state_q[i] == ST_PENDING) && !abort_edge[i];
      if (state_q[i] == ST_PENDING || state_q[i] == ST_RUN) all_idle = 1'b0;
    end
    grant_en = (active_cnt < CW'(MAX_ACTIVE));
  end

  spmv_rr_arbiter #(.N(N)) u_arb (
    .aclk    (aclk),
    .aresetn (aresetn),
    .req     (req),
    .en      (grant_en),
    .grant   (grant)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      start_q      <= '1;
      abort_q      <= '1;
      empty_q      <= '0;
      aborted_q    <= '0;
      kern_start   <= '0;
      kern_abort   <= '0;
      kern_row_num <= '0;
      kern_nnz_num <= '0;
      for (int i = 0; i < N; i++) begin
        state_q[i]   <= ST_IDLE;
        run_cnt_q[i] <= '0;
        launch_q[i]  <= '0;
      end
    end else begin
      start_q    <= start_now;
      abort_q    <= abort_now;
      kern_start <= '0;
      kern_abort <= '0;
      for (int i = 0; i < N; i++) begin
        case (state_q[i])
          ST_IDLE, ST_DONE: begin
            if (start_edge[i] && !abort_edge[i]) begin
              if (row_cfg[i] == '0 || nnz_cfg[i] == '0) begin
                state_q[i] <= ST_DONE;
                empty_q[i] <= 1'b1;
              end else begin
                state_q[i]   <= ST_PENDING;
                empty_q[i]   <= 1'b0;
                aborted_q[i] <= 1'b0;
              end
            end
          end
          ST_PENDING: begin
            if (abort_edge[i]) begin
              state_q[i]   <= ST_DONE;
              aborted_q[i] <= 1'b1;
            end else if (grant[i]) begin
              state_q[i]                <= ST_RUN;
              kern_start[i]             <= 1'b1;
              kern_row_num[32*i +: 32]  <= row_cfg[i];
              kern_nnz_num[32*i +: 32]  <= nnz_cfg[i];
              run_cnt_q[i]              <= '0;
            end
          end
          ST_RUN: begin
            if (kern_done[i]) begin
              state_q[i]  <= ST_DONE;
              launch_q[i] <= launch_q[i] + 16'd1;
            end else if (run_cnt_q[i] != '1) begin
              run_cnt_q[i] <= run_cnt_q[i] + 32'd1;
            end
            if (abort_edge[i]) begin
              kern_abort[i] <= 1'b1;
              aborted_q[i]  <= 1'b1;
            end
          end
          default: state_q[i] <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      status_wire[STAT_STRIDE*i +: 32]      = pack_status(state_q[i], empty_q[i], aborted_q[i], launch_q[i]);
      status_wire[STAT_STRIDE*i + 32 +: 32] = run_cnt_q[i];
    end
  end

endmodule

// File: tb/tb_spmv_kernel_scheduler.sv
// Directed scenarios plus a randomized run against a cycle-level reference model.
module tb_spmv_kernel_scheduler;

  localparam int N    = 4;
  localparam int MAXA = 2;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [96*N-1:0] config_wire;
  logic [N-1:0]    kern_start, kern_abort, kern_done;
  logic [32*N-1:0] kern_row_num, kern_nnz_num;
  logic [64*N-1:0] status_wire;
  logic            all_idle;

  logic [31:0] cfg_ctrl [N];
  logic [31:0] cfg_row  [N];
  logic [31:0] cfg_nnz  [N];

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_state [N];
  bit          m_empty [N];
  bit          m_abt   [N];
  int unsigned m_cnt   [N];
  int          m_lc    [N];
  bit [1:0]    m_cq    [N];
  logic [31:0] m_row   [N];
  logic [31:0] m_nnz   [N];
  int          m_ptr;
  logic [N-1:0] m_start, m_abort;

  always #5 aclk = ~aclk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      config_wire[96*i +: 32]      = cfg_ctrl[i];
      config_wire[96*i + 32 +: 32] = cfg_row[i];
      config_wire[96*i + 64 +: 32] = cfg_nnz[i];
    end
  end

  spmv_kernel_scheduler #(.CONF_NUM_KERNEL(N), .MAX_ACTIVE(MAXA)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .config_wire  (config_wire),
    .kern_start   (kern_start),
    .kern_row_num (kern_row_num),
    .kern_nnz_num (kern_nnz_num),
    .kern_abort   (kern_abort),
    .kern_done    (kern_done),
    .status_wire  (status_wire),
    .all_idle     (all_idle)
  );

  function automatic logic [31:0] stat_word(input int i);
    return status_wire[64*i +: 32];
  endfunction

  function automatic logic [31:0] run_word(input int i);
    return status_wire[64*i + 32 +: 32];
  endfunction

  function automatic logic [31:0] model_status(input int i);
    return 32'(m_state[i]) + (m_empty[i] ? 32'd16 : 32'd0) + (m_abt[i] ? 32'd32 : 32'd0)
           + (32'(m_lc[i]) << 16);
  endfunction

  function automatic bit model_all_idle();
    for (int i = 0; i < N; i++) if (m_state[i] == 1 || m_state[i] == 2) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model by one clock using the inputs the DUT is about to sample
  task automatic model_step();
    int active, g;
    bit se [N];
    bit ae [N];
    m_start = '0;
    m_abort = '0;
    if (!aresetn) begin
      for (int i = 0; i < N; i++) begin
        m_state[i] = 0; m_empty[i] = 0; m_abt[i] = 0; m_cnt[i] = 0; m_lc[i] = 0;
        m_cq[i] = 2'b11; m_row[i] = '0; m_nnz[i] = '0;
      end
      m_ptr = 0;
      return;
    end
    active = 0;
    for (int i = 0; i < N; i++) begin
      se[i] = cfg_ctrl[i][0] && !m_cq[i][0];
      ae[i] = cfg_ctrl[i][1] && !m_cq[i][1];
      if (m_state[i] == 2) active++;
    end
    g = -1;
    if (active < MAXA)
      for (int k = 0; k < N; k++)
        if (g < 0 && m_state[(m_ptr + k) % N] == 1 && !ae[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    for (int i = 0; i < N; i++) begin
      case (m_state[i])
        0, 3: if (se[i] && !ae[i]) begin
          if (cfg_row[i] == 0 || cfg_nnz[i] == 0) begin m_state[i] = 3; m_empty[i] = 1; end
          else begin m_state[i] = 1; m_empty[i] = 0; m_abt[i] = 0; end
        end
        1: if (ae[i]) begin m_state[i] = 3; m_abt[i] = 1; end
           else if (g == i) begin
             m_state[i] = 2; m_start[i] = 1'b1; m_row[i] = cfg_row[i]; m_nnz[i] = cfg_nnz[i]; m_cnt[i] = 0;
           end
        default: begin
          if (kern_done[i]) begin m_state[i] = 3; m_lc[i] = (m_lc[i] + 1) % 65536; end
          else if (m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i]++;
          if (ae[i]) begin m_abort[i] = 1'b1; m_abt[i] = 1; end
        end
      endcase
      m_cq[i] = cfg_ctrl[i][1:0];
    end
    if (g >= 0) m_ptr = (g + 1) % N;
  endtask

  task automatic tick();
    model_step();
    @(posedge aclk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      cfg_ctrl[i] = '0; cfg_row[i] = '0; cfg_nnz[i] = '0;
    end
    kern_done = '0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    ticks(2);
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    for (int i = 0; i < N; i++) cfg_ctrl[i] = 32'h3;
    aresetn = 1'b0;
    ticks(2);
    checks++; if (status_wire !== '0) begin errors++; $display("FAIL reset_status got %h want 0", status_wire); end
    checks++; if (all_idle !== 1'b1) begin errors++; $display("FAIL reset_all_idle got %b want 1", all_idle); end
    checks++; if (kern_start !== '0 || kern_abort !== '0) begin errors++; $display("FAIL reset_pulses got %b/%b want 0/0", kern_start, kern_abort); end
    checks++; if (kern_row_num !== '0 || kern_nnz_num !== '0) begin errors++; $display("FAIL reset_counts got %h/%h want 0", kern_row_num, kern_nnz_num); end
    aresetn = 1'b1;
    ticks(3);
    checks++; if (kern_start !== '0) begin errors++; $display("FAIL reset_held_ctrl got %b want 0", kern_start); end
    clear_inputs();
    tick();
  endtask

  task automatic test_basic_launch();
    clear_inputs();
    do_reset();
    cfg_row[0] = 32'd8; cfg_nnz[0] = 32'd20; cfg_ctrl[0] = 32'h1;
    tick();
    checks++; if (stat_word(0) !== 32'h1 || kern_start !== '0) begin errors++; $display("FAIL basic_pending got %h/%b want 00000001/0000", stat_word(0), kern_start); end
    tick();
    checks++; if (kern_start !== 4'b0001) begin errors++; $display("FAIL basic_start got %b want 0001", kern_start); end
    checks++; if (kern_row_num[31:0] !== 32'd8 || kern_nnz_num[31:0] !== 32'd20) begin errors++; $display("FAIL basic_latch got %0d/%0d want 8/20", kern_row_num[31:0], kern_nnz_num[31:0]); end
    tick();
    checks++; if (kern_start !== '0) begin errors++; $display("FAIL basic_start_width got %b want 0000", kern_start); end
    cfg_row[0] = 32'd99;
    ticks(9);
    kern_done = 4'b0001;
    tick();
    kern_done = '0;
    checks++; if (stat_word(0) !== 32'h0001_0003) begin errors++; $display("FAIL basic_status got %h want 00010003", stat_word(0)); end
    checks++; if (run_word(0) !== 32'd10) begin errors++; $display("FAIL basic_cycles got %0d want 10", run_word(0)); end
    checks++; if (kern_row_num[31:0] !== 32'd8) begin errors++; $display("FAIL basic_row_hold got %0d want 8", kern_row_num[31:0]); end
    checks++; if (all_idle !== 1'b1) begin errors++; $display("FAIL basic_all_idle got %b want 1", all_idle); end
  endtask

  task automatic test_concurrency();
    clear_inputs();
    do_reset();
    for (int i = 0; i < N; i++) begin cfg_row[i] = 32'(i + 1); cfg_nnz[i] = 32'd10; cfg_ctrl[i] = 32'h1; end
    tick();
    checks++; if (all_idle !== 1'b0) begin errors++; $display("FAIL conc_busy got %b want 0", all_idle); end
    tick();
    checks++; if (kern_start !== 4'b0001) begin errors++; $display("FAIL conc_start0 got %b want 0001", kern_start); end
    tick();
    checks++; if (kern_start !== 4'b0010) begin errors++; $display("FAIL conc_start1 got %b want 0010", kern_start); end
    tick();
    checks++; if (kern_start !== '0) begin errors++; $display("FAIL conc_limit got %b want 0000", kern_start); end
    checks++; if (stat_word(2) !== 32'h1 || stat_word(3) !== 32'h1) begin errors++; $display("FAIL conc_pending got %h/%h want 1/1", stat_word(2), stat_word(3)); end
    ticks(3);
    kern_done = 4'b0010;
    tick();
    kern_done = '0;
    checks++; if (kern_start !== '0) begin errors++; $display("FAIL conc_slot_delay got %b want 0000", kern_start); end
    tick();
    checks++; if (kern_start !== 4'b0100) begin errors++; $display("FAIL conc_start2 got %b want 0100", kern_start); end
    checks++; if (kern_row_num[64 +: 32] !== 32'd3) begin errors++; $display("FAIL conc_row2 got %0d want 3", kern_row_num[64 +: 32]); end
  endtask

  task automatic test_empty();
    bit seen;
    clear_inputs();
    do_reset();
    cfg_row[1] = 32'd5; cfg_nnz[1] = 32'd0; cfg_ctrl[1] = 32'h1;
    seen = 1'b0;
    repeat (6) begin tick(); if (kern_start[1]) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL empty_no_start got %b want 0", seen); end
    checks++; if (stat_word(1) !== 32'h13) begin errors++; $display("FAIL empty_status got %h want 00000013", stat_word(1)); end
  endtask

  task automatic test_abort();
    clear_inputs();
    do_reset();
    cfg_row[0] = 32'd4; cfg_nnz[0] = 32'd4; cfg_ctrl[0] = 32'h1;
    tick();
    cfg_ctrl[0] = 32'h3;
    tick();
    checks++; if (kern_start !== '0 || stat_word(0) !== 32'h23) begin errors++; $display("FAIL abort_pending got %b/%h want 0000/00000023", kern_start, stat_word(0)); end
    cfg_row[2] = 32'd6; cfg_nnz[2] = 32'd6; cfg_ctrl[2] = 32'h1;
    ticks(2);
    checks++; if (kern_start !== 4'b0100) begin errors++; $display("FAIL abort_run_start got %b want 0100", kern_start); end
    cfg_ctrl[2] = 32'h3;
    tick();
    checks++; if (kern_abort !== 4'b0100 || stat_word(2) !== 32'h22) begin errors++; $display("FAIL abort_run_pulse got %b/%h want 0100/00000022", kern_abort, stat_word(2)); end
    tick();
    checks++; if (kern_abort !== '0 || stat_word(2) !== 32'h22) begin errors++; $display("FAIL abort_run_hold got %b/%h want 0000/00000022", kern_abort, stat_word(2)); end
    kern_done = 4'b0100;
    tick();
    kern_done = '0;
    checks++; if (stat_word(2) !== 32'h0001_0023) begin errors++; $display("FAIL abort_run_done got %h want 00010023", stat_word(2)); end
  endtask

  task automatic test_reset_robust();
    bit seen_start, seen_abort;
    clear_inputs();
    do_reset();
    cfg_row[0] = 32'd3; cfg_nnz[0] = 32'd3; cfg_ctrl[0] = 32'h1;
    ticks(3);
    checks++; if (stat_word(0) !== 32'h2) begin errors++; $display("FAIL robust_run got %h want 00000002", stat_word(0)); end
    aresetn = 1'b0;
    seen_abort = 1'b0;
    repeat (2) begin tick(); if (kern_abort != '0) seen_abort = 1'b1; end
    aresetn = 1'b1;
    seen_start = 1'b0;
    repeat (6) begin tick(); if (kern_start != '0) seen_start = 1'b1; if (kern_abort != '0) seen_abort = 1'b1; end
    checks++; if (seen_start !== 1'b0 || seen_abort !== 1'b0) begin errors++; $display("FAIL robust_no_pulse got %b/%b want 0/0", seen_start, seen_abort); end
    checks++; if (all_idle !== 1'b1 || stat_word(0) !== '0) begin errors++; $display("FAIL robust_idle got %b/%h want 1/00000000", all_idle, stat_word(0)); end
    cfg_ctrl[0] = 32'h0;
    tick();
    cfg_ctrl[0] = 32'h1;
    ticks(2);
    checks++; if (kern_start !== 4'b0001) begin errors++; $display("FAIL robust_restart got %b want 0001", kern_start); end
    kern_done = 4'b1000;
    tick();
    kern_done = '0;
    tick();
    checks++; if (stat_word(3) !== '0) begin errors++; $display("FAIL robust_spurious_idle got %h want 00000000", stat_word(3)); end
    kern_done = 4'b0001;
    tick();
    kern_done = 4'b0001;
    tick();
    kern_done = '0;
    checks++; if (stat_word(0) !== 32'h0001_0003) begin errors++; $display("FAIL robust_spurious_done got %h want 00010003", stat_word(0)); end
  endtask

  task automatic test_random();
    clear_inputs();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0)  cfg_ctrl[i][0] = ~cfg_ctrl[i][0];
        if ($urandom_range(0, 19) == 0) cfg_ctrl[i][1] = ~cfg_ctrl[i][1];
        if ($urandom_range(0, 15) == 0) begin
          cfg_row[i] = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
          cfg_nnz[i] = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
        end
        kern_done[i] = (m_state[i] == 2 && $urandom_range(0, 9) == 0) || ($urandom_range(0, 49) == 0);
      end
      tick();
      checks++; if (kern_start !== m_start) begin errors++; $display("FAIL rand_start c=%0d got %b want %b", c, kern_start, m_start); end
      checks++; if (kern_abort !== m_abort) begin errors++; $display("FAIL rand_abort c=%0d got %b want %b", c, kern_abort, m_abort); end
      checks++; if (all_idle !== model_all_idle()) begin errors++; $display("FAIL rand_all_idle c=%0d got %b want %b", c, all_idle, model_all_idle()); end
      for (int i = 0; i < N; i++) begin
        checks++; if (stat_word(i) !== model_status(i)) begin errors++; $display("FAIL rand_status%0d c=%0d got %h want %h", i, c, stat_word(i), model_status(i)); end
        checks++; if (run_word(i) !== m_cnt[i]) begin errors++; $display("FAIL rand_cycles%0d c=%0d got %0d want %0d", i, c, run_word(i), m_cnt[i]); end
        checks++; if (kern_row_num[32*i +: 32] !== m_row[i] || kern_nnz_num[32*i +: 32] !== m_nnz[i]) begin
          errors++; $display("FAIL rand_latch%0d c=%0d got %h/%h want %h/%h", i, c, kern_row_num[32*i +: 32], kern_nnz_num[32*i +: 32], m_row[i], m_nnz[i]);
        end
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_basic_launch();
    test_concurrency();
    test_empty();
    test_abort();
    test_reset_robust();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
